// File: rtl/instr_fetch_pkg.sv
// Shared fetch-path definitions: FSM state encoding, next-PC select codes and default widths.
// Reused by the pc and decode blocks so every stage agrees on the encoding.
package instr_fetch_pkg;

    localparam int          ADDR_W_DEF   = 8;
    localparam int          INSTR_W_DEF  = 8;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_HOLD  = 2'd0,
        NPC_INC   = 2'd1,
        NPC_REDIR = 2'd2,
        NPC_RESET = 2'd3
    } npc_sel_e;

endpackage

// File: rtl/instr_fetch_next_pc_mux.sv
// Combinational next-PC select feeding pc.NextI: hold, increment (wrapping), redirect or boot PC.
module next_pc_mux
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  npc_sel_e          sel_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] redir_pc_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_i;
        unique case (sel_i)
            NPC_HOLD:  next_pc_o = pc_i;
            // Wraps naturally at the top of the address space.
            NPC_INC:   next_pc_o = pc_i + ADDR_W'(1);
            NPC_REDIR: next_pc_o = redir_pc_i;
            NPC_RESET: next_pc_o = RESET_PC;
            default:   next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Multicycle fetch sequencer: issues a ROM read for pc_i, captures the word in an
// instruction register and hands it to decode over valid/ready, steering the PC.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [ADDR_W-1:0]  next_pc_o,
    output logic               imem_en_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               halt_i,
    input  logic               redir_i,
    input  logic [ADDR_W-1:0]  redir_pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i
);

    fetch_state_e       state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               valid_q;
    npc_sel_e           npc_sel;

    // Redirect outranks everything except the boot cycle, where pc must load RESET_PC.
    always_comb begin
        npc_sel = NPC_HOLD;
        if (state_q == S_BOOT)
            npc_sel = NPC_RESET;
        else if (redir_i)
            npc_sel = NPC_REDIR;
        else if (state_q == S_OUT && instr_ready_i)
            npc_sel = NPC_INC;
    end

    next_pc_mux #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_next_pc_mux (
        .sel_i      (npc_sel),
        .pc_i       (pc_i),
        .redir_pc_i (redir_pc_i),
        .next_pc_o  (next_pc_o)
    );

    assign imem_en_o     = (state_q == S_REQ) && !halt_i;
    assign imem_addr_o   = pc_i;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_BOOT: state_q <= S_REQ;
                S_REQ: begin
                    // A read issued alongside a redirect is simply never collected.
                    if (redir_i)
                        state_q <= S_REQ;
                    else if (!halt_i)
                        state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (redir_i) begin
                        state_q <= S_REQ;
                    end else begin
                        instr_q    <= imem_rdata_i;
                        instr_pc_q <= pc_i;
                        valid_q    <= 1'b1;
                        state_q    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (redir_i || instr_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural pc register and 1-cycle sync ROM.
module tb_instr_fetch;

    logic       clk;
    logic       rst_n;
    logic [7:0] pc;
    logic [7:0] next_pc;
    logic       imem_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       halt;
    logic       redir;
    logic [7:0] redir_pc;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;

    logic [7:0] rom [256];
    int total;
    int bad;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc),
        .next_pc_o     (next_pc),
        .imem_en_o     (imem_en),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .halt_i        (halt),
        .redir_i       (redir),
        .redir_pc_i    (redir_pc),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pc <= next_pc;
    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hC3;
        rom[0] = 8'hA5;
        rst_n = 1'b0; halt = 1'b0; redir = 1'b0; redir_pc = 8'h00; instr_ready = 1'b1;
        imem_rdata = 8'h00;

        // reset state
        tick(); tick();
        #1;
        chk("rst_valid", 8'(instr_valid), 8'h00);
        chk("rst_instr", instr, 8'h00);
        chk("rst_ipc", instr_pc, 8'h00);
        chk("rst_en", 8'(imem_en), 8'h00);
        chk("rst_npc", next_pc, 8'h00);

        // 1: boot and first fetch
        rst_n = 1'b1;
        #1;
        chk("boot_npc", next_pc, 8'h00);
        chk("boot_en", 8'(imem_en), 8'h00);
        tick(); #1;
        chk("t1_en", 8'(imem_en), 8'h01);
        chk("t1_addr", imem_addr, 8'h00);
        chk("t1_npc", next_pc, 8'h00);
        tick(); #1;
        chk("t1_wait_en", 8'(imem_en), 8'h00);
        chk("t1_wait_vld", 8'(instr_valid), 8'h00);
        tick(); #1;
        chk("t1_vld", 8'(instr_valid), 8'h01);
        chk("t1_instr", instr, 8'hA5);
        chk("t1_ipc", instr_pc, 8'h00);
        chk("t1_npc_inc", next_pc, 8'h01);
        tick();

        // 2: decode stalls for 5 cycles
        instr_ready = 1'b0;
        #1;
        chk("t2_en", 8'(imem_en), 8'h01);
        chk("t2_addr", imem_addr, 8'h01);
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_stall_vld", 8'(instr_valid), 8'h01);
            chk("t2_stall_instr", instr, 8'hC2);
            chk("t2_stall_ipc", instr_pc, 8'h01);
            chk("t2_stall_en", 8'(imem_en), 8'h00);
            chk("t2_stall_npc", next_pc, 8'h01);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("t2_npc_inc", next_pc, 8'h02);
        tick(); #1;
        chk("t2_refetch_en", 8'(imem_en), 8'h01);
        chk("t2_refetch_addr", imem_addr, 8'h02);

        // 3: redirect to FF in S_REQ, then wrap on accept
        redir = 1'b1; redir_pc = 8'hFF;
        #1;
        chk("t3_redir_npc", next_pc, 8'hFF);
        chk("t3_redir_en", 8'(imem_en), 8'h01);
        tick();
        redir = 1'b0;
        #1;
        chk("t3_addr_ff", imem_addr, 8'hFF);
        chk("t3_en_ff", 8'(imem_en), 8'h01);
        tick(); tick(); #1;
        chk("t3_instr", instr, 8'h3C);
        chk("t3_ipc", instr_pc, 8'hFF);
        chk("t3_npc_wrap", next_pc, 8'h00);
        tick(); #1;
        chk("t3_wrap_en", 8'(imem_en), 8'h01);
        chk("t3_wrap_addr", imem_addr, 8'h00);

        // 4: redirect in S_WAIT drops the fetch; redirect in S_OUT beats PC+1
        tick();
        redir = 1'b1; redir_pc = 8'h55;
        #1;
        chk("t4_wait_npc", next_pc, 8'h55);
        tick();
        redir = 1'b0;
        #1;
        chk("t4_no_vld", 8'(instr_valid), 8'h00);
        chk("t4_not_latched", instr_pc, 8'hFF);
        chk("t4_en", 8'(imem_en), 8'h01);
        chk("t4_addr", imem_addr, 8'h55);
        tick(); tick(); #1;
        chk("t4_vld", 8'(instr_valid), 8'h01);
        chk("t4_instr", instr, 8'h96);
        chk("t4_ipc", instr_pc, 8'h55);
        redir = 1'b1; redir_pc = 8'h55; instr_ready = 1'b1;
        #1;
        chk("t4_out_npc", next_pc, 8'h55);
        tick();
        redir = 1'b0;
        #1;
        chk("t4_out_vld", 8'(instr_valid), 8'h00);
        chk("t4_out_en", 8'(imem_en), 8'h01);
        chk("t4_out_addr", imem_addr, 8'h55);

        // 5: halt in S_REQ, then halt ignored in S_WAIT
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_halt_en", 8'(imem_en), 8'h00);
            chk("t5_halt_npc", next_pc, 8'h55);
            tick();
        end
        halt = 1'b0;
        #1;
        chk("t5_rel_en", 8'(imem_en), 8'h01);
        chk("t5_rel_addr", imem_addr, 8'h55);
        tick();
        halt = 1'b1;
        #1;
        chk("t5_wait_npc", next_pc, 8'h55);
        tick();
        halt = 1'b0;
        #1;
        chk("t5_vld", 8'(instr_valid), 8'h01);
        chk("t5_instr", instr, 8'h96);

        // 6: async reset during S_WAIT
        tick(); #1;
        chk("t6_addr", imem_addr, 8'h56);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 8'(instr_valid), 8'h00);
        chk("t6_rst_instr", instr, 8'h00);
        chk("t6_rst_ipc", instr_pc, 8'h00);
        chk("t6_rst_en", 8'(imem_en), 8'h00);
        chk("t6_rst_npc", next_pc, 8'h00);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("t6_boot_npc", next_pc, 8'h00);
        chk("t6_boot_en", 8'(imem_en), 8'h00);
        tick(); #1;
        chk("t6_en", 8'(imem_en), 8'h01);
        chk("t6_addr0", imem_addr, 8'h00);
        tick(); tick(); #1;
        chk("t6_vld", 8'(instr_valid), 8'h01);
        chk("t6_instr", instr, 8'hA5);
        chk("t6_ipc", instr_pc, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
